// File: rtl/pri_queue_sorted.sv
// Sorted priority queue: systolic register array holding up to DEPTH keys,
// best key always at entry 0. One insert and/or removal per clock.
module pri_queue_sorted #(
    parameter int unsigned  WIDTH     = 8,
    parameter int unsigned  DEPTH     = 8,
    parameter bit           MAX_FIRST = 1'b1,
    localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic             ck,
    input  logic             r,
    input  logic             clear,
    input  logic             loadIn,
    input  logic [WIDTH-1:0] newVal,
    input  logic             shiftOut,
    output logic [WIDTH-1:0] top,
    output logic             topValid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] key_q   [DEPTH];
    logic [WIDTH-1:0] key_d   [DEPTH];
    logic [WIDTH-1:0] nxt_key [DEPTH];
    logic [WIDTH-1:0] prv_key [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] nxt_valid;
    logic [DEPTH-1:0] prv_valid;
    logic [DEPTH-1:0] bi;
    logic [DEPTH-1:0] bs;
    logic [DEPTH-1:0] bp;
    logic [CW-1:0]    count_d;
    logic             ovf_d;
    logic             udf_d;
    logic             do_rep;

    function automatic logic better(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return MAX_FIRST ? (a > b) : (a < b);
    endfunction

    // Per-entry compare vector; thermometer-shaped because the array is sorted.
    // bs looks one entry ahead (replace), bp one entry behind (insert).
    always_comb begin
        bi = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bi[i] = !valid_q[i] || better(newVal, key_q[i]);
        end
        bs = {1'b1, bi[DEPTH-1:1]};
        bp = {bi[DEPTH-2:0], 1'b0};
    end

    // Neighbour views of the array used by the shift paths.
    always_comb begin
        nxt_key[DEPTH-1] = '0;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            nxt_key[i] = key_q[i+1];
        end
        prv_key[0] = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            prv_key[i] = key_q[i-1];
        end
        nxt_valid = {1'b0, valid_q[DEPTH-1:1]};
        prv_valid = {valid_q[DEPTH-2:0], 1'b0};
    end

    // Next-state selection: each entry picks keep / newVal / previous / next.
    always_comb begin
        key_d   = key_q;
        valid_d = valid_q;
        count_d = count;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        do_rep  = loadIn && shiftOut && valid_q[0];

        if (clear) begin
            key_d   = '{default: '0};
            valid_d = '0;
            count_d = '0;
        end else if (do_rep) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!(i != 0 && bi[i])) begin
                    if (bs[i]) begin
                        key_d[i]   = newVal;
                        valid_d[i] = 1'b1;
                    end else begin
                        key_d[i]   = nxt_key[i];
                        valid_d[i] = nxt_valid[i];
                    end
                end
            end
        end else if (loadIn) begin
            ovf_d = valid_q[DEPTH-1];
            if (!valid_q[DEPTH-1]) begin
                count_d = count + CW'(1);
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (bp[i]) begin
                    key_d[i]   = prv_key[i];
                    valid_d[i] = prv_valid[i];
                end else if (bi[i]) begin
                    key_d[i]   = newVal;
                    valid_d[i] = 1'b1;
                end
            end
        end else if (shiftOut) begin
            if (valid_q[0]) begin
                key_d   = nxt_key;
                valid_d = nxt_valid;
                count_d = count - CW'(1);
            end else begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            key_q     <= '{default: '0};
            valid_q   <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            key_q     <= key_d;
            valid_q   <= valid_d;
            count     <= count_d;
            full      <= valid_d[DEPTH-1];
            empty     <= !valid_d[0];
            overflow  <= ovf_d;
            underflow <= udf_d;
        end
    end

    assign top      = key_q[0];
    assign topValid = valid_q[0];

endmodule

// File: tb/tb_pri_queue_sorted.sv
// Bench for pri_queue_sorted: a max-first and a min-first instance (DEPTH=4)
// checked against a queue-based reference model.
module tb_pri_queue_sorted;

    localparam int unsigned D = 4;

    logic ck = 1'b0;
    logic r  = 1'b0;

    logic       a_clear = 0, a_load = 0, a_shift = 0;
    logic [7:0] a_val   = '0;
    logic [7:0] a_top;
    logic       a_tv, a_full, a_empty, a_ovf, a_udf;
    logic [2:0] a_cnt;

    logic       b_clear = 0, b_load = 0, b_shift = 0;
    logic [7:0] b_val   = '0;
    logic [7:0] b_top;
    logic       b_tv, b_full, b_empty, b_ovf, b_udf;
    logic [2:0] b_cnt;

    int checks   = 0;
    int failures = 0;

    bit         use_b   = 1'b0;
    logic [7:0] mq[$];
    bit         exp_ovf = 1'b0;
    bit         exp_udf = 1'b0;

    localparam logic [15:0] RESET_VEC = 16'h0004;

    always #5 ck = ~ck;

    pri_queue_sorted #(.WIDTH(8), .DEPTH(D), .MAX_FIRST(1'b1)) dut_a (
        .ck(ck), .r(r), .clear(a_clear), .loadIn(a_load), .newVal(a_val),
        .shiftOut(a_shift), .top(a_top), .topValid(a_tv), .count(a_cnt),
        .full(a_full), .empty(a_empty), .overflow(a_ovf), .underflow(a_udf)
    );

    pri_queue_sorted #(.WIDTH(8), .DEPTH(D), .MAX_FIRST(1'b0)) dut_b (
        .ck(ck), .r(r), .clear(b_clear), .loadIn(b_load), .newVal(b_val),
        .shiftOut(b_shift), .top(b_top), .topValid(b_tv), .count(b_cnt),
        .full(b_full), .empty(b_empty), .overflow(b_ovf), .underflow(b_udf)
    );

    function automatic logic [15:0] obs_vec(input bit b);
        if (b) return {b_top, b_tv, b_cnt, b_full, b_empty, b_ovf, b_udf};
        return {a_top, a_tv, a_cnt, a_full, a_empty, a_ovf, a_udf};
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [7:0] t;
        int n;
        n = mq.size();
        t = (n > 0) ? mq[0] : 8'd0;
        return {t, n > 0, 3'(n), n == int'(D), n == 0, exp_ovf, exp_udf};
    endfunction

    function automatic bit tb_better(input logic [7:0] v, input logic [7:0] k);
        return use_b ? (v < k) : (v > k);
    endfunction

    // New key goes behind every key it does not strictly beat; anything past D falls off.
    function automatic void model_insert(input logic [7:0] v);
        int pos;
        pos = mq.size();
        for (int i = 0; i < mq.size(); i++) begin
            if (tb_better(v, mq[i])) begin
                pos = i;
                break;
            end
        end
        mq.insert(pos, v);
        if (mq.size() > int'(D)) void'(mq.pop_back());
    endfunction

    function automatic void model_op(input bit clr, input bit ld, input bit sh, input logic [7:0] v);
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        if (clr) begin
            mq.delete();
        end else if (ld && sh && mq.size() > 0) begin
            void'(mq.pop_front());
            model_insert(v);
        end else if (ld) begin
            exp_ovf = (mq.size() == int'(D));
            model_insert(v);
        end else if (sh) begin
            if (mq.size() == 0) exp_udf = 1'b1;
            else void'(mq.pop_front());
        end
    endfunction

    // Drive one operation on the selected instance, clock it, advance the model.
    task automatic step(input bit clr, input bit ld, input bit sh, input logic [7:0] v);
        @(negedge ck);
        if (use_b) begin
            b_clear = clr; b_load = ld; b_shift = sh; b_val = v;
        end else begin
            a_clear = clr; a_load = ld; a_shift = sh; a_val = v;
        end
        @(posedge ck);
        #1;
        model_op(clr, ld, sh, v);
        a_clear = 0; a_load = 0; a_shift = 0; a_val = 8'bx;
        b_clear = 0; b_load = 0; b_shift = 0; b_val = 8'bx;
    endtask

    task automatic test_reset();
        r = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k != 0) !== RESET_VEC) begin
                failures++;
                $display("FAIL reset inst%0d: got %h want %h", k, obs_vec(k != 0), RESET_VEC);
            end
        end
        @(negedge ck);
        r = 1'b1;
        mq.delete();
    endtask

    task automatic test_insert_order();
        logic [7:0] ins [4]     = '{8'd5, 8'd9, 8'd2, 8'd9};
        logic [7:0] tops [4]    = '{8'd5, 8'd9, 8'd9, 8'd9};
        logic [7:0] drained [4] = '{8'd9, 8'd9, 8'd5, 8'd2};
        use_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, ins[i]);
            checks++;
            if (a_top !== tops[i] || obs_vec(0) !== exp_vec()) begin
                failures++;
                $display("FAIL insert_order %0d: got %h want top %0d vec %h", i, obs_vec(0), tops[i], exp_vec());
            end
        end
        checks++;
        if (a_full !== 1'b1 || a_cnt !== 3'd4) begin
            failures++;
            $display("FAIL insert_full: got full=%b count=%0d want full=1 count=4", a_full, a_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_top !== drained[i]) begin
                failures++;
                $display("FAIL drain_order %0d: got %0d want %0d", i, a_top, drained[i]);
            end
            step(0, 0, 1, 8'bx);
        end
        checks++;
        if (a_empty !== 1'b1 || obs_vec(0) !== exp_vec()) begin
            failures++;
            $display("FAIL drain_empty: got %h want %h", obs_vec(0), exp_vec());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] fill [4] = '{8'd9, 8'd9, 8'd5, 8'd2};
        logic [7:0] want [4] = '{8'd9, 8'd9, 8'd7, 8'd5};
        use_b = 1'b0;
        step(1, 0, 0, 8'bx);
        for (int i = 0; i < 4; i++) step(0, 1, 0, fill[i]);
        step(0, 1, 0, 8'd7);
        checks++;
        if (a_ovf !== 1'b1 || obs_vec(0) !== exp_vec()) begin
            failures++;
            $display("FAIL overflow_drop_last: got %h want %h", obs_vec(0), exp_vec());
        end
        step(0, 0, 0, 8'bx);
        checks++;
        if (a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL overflow_pulse_len: got %b want 0", a_ovf);
        end
        step(0, 1, 0, 8'd1);
        checks++;
        if (a_ovf !== 1'b1 || a_cnt !== 3'd4 || obs_vec(0) !== exp_vec()) begin
            failures++;
            $display("FAIL overflow_drop_new: got %h want %h", obs_vec(0), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_top !== want[i]) begin
                failures++;
                $display("FAIL overflow_contents %0d: got %0d want %0d", i, a_top, want[i]);
            end
            step(0, 0, 1, 8'bx);
        end
    endtask

    task automatic test_replace();
        logic [7:0] fill [4] = '{8'd9, 8'd7, 8'd5, 8'd3};
        logic [7:0] want [4] = '{8'd7, 8'd6, 8'd5, 8'd3};
        use_b = 1'b0;
        step(1, 0, 0, 8'bx);
        for (int i = 0; i < 4; i++) step(0, 1, 0, fill[i]);
        step(0, 1, 1, 8'd6);
        checks++;
        if (a_top !== 8'd7 || a_cnt !== 3'd4 || a_ovf !== 1'b0 || a_udf !== 1'b0
            || obs_vec(0) !== exp_vec()) begin
            failures++;
            $display("FAIL replace_full: got %h want top 7 count 4 vec %h", obs_vec(0), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_top !== want[i]) begin
                failures++;
                $display("FAIL replace_contents %0d: got %0d want %0d", i, a_top, want[i]);
            end
            step(0, 0, 1, 8'bx);
        end
    endtask

    task automatic test_empty_ops();
        use_b = 1'b0;
        step(1, 0, 0, 8'bx);
        step(0, 0, 1, 8'bx);
        checks++;
        if (a_udf !== 1'b1 || a_cnt !== 3'd0 || obs_vec(0) !== exp_vec()) begin
            failures++;
            $display("FAIL underflow: got %h want %h", obs_vec(0), exp_vec());
        end
        step(0, 1, 1, 8'd4);
        checks++;
        if (a_top !== 8'd4 || a_cnt !== 3'd1 || a_udf !== 1'b0 || a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL replace_empty: got %h want top 4 count 1 no flags", obs_vec(0));
        end
    endtask

    task automatic test_async_reset();
        use_b = 1'b0;
        step(1, 0, 0, 8'bx);
        step(0, 1, 0, 8'd1);
        step(0, 1, 0, 8'd2);
        step(0, 1, 0, 8'd3);
        checks++;
        if (a_cnt !== 3'd3) begin
            failures++;
            $display("FAIL async_pre_count: got %0d want 3", a_cnt);
        end
        #2 r = 1'b0;
        #1;
        checks++;
        if (obs_vec(0) !== RESET_VEC) begin
            failures++;
            $display("FAIL async_reset: got %h want %h", obs_vec(0), RESET_VEC);
        end
        @(negedge ck);
        r = 1'b1;
        mq.delete();
        step(0, 1, 0, 8'd8);
        checks++;
        if (a_top !== 8'd8 || a_cnt !== 3'd1) begin
            failures++;
            $display("FAIL async_release_insert: got top %0d count %0d want 8 1", a_top, a_cnt);
        end
    endtask

    task automatic test_min_first();
        logic [7:0] ins [3]  = '{8'd5, 8'd9, 8'd2};
        logic [7:0] want [3] = '{8'd2, 8'd5, 8'd9};
        use_b = 1'b1;
        step(1, 0, 0, 8'bx);
        for (int i = 0; i < 3; i++) step(0, 1, 0, ins[i]);
        checks++;
        if (b_top !== 8'd2 || obs_vec(1) !== exp_vec()) begin
            failures++;
            $display("FAIL min_first_top: got %h want top 2 vec %h", obs_vec(1), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b_top !== want[i]) begin
                failures++;
                $display("FAIL min_first_drain %0d: got %0d want %0d", i, b_top, want[i]);
            end
            step(0, 0, 1, 8'bx);
        end
        step(0, 1, 0, 8'd3);
        step(1, 1, 0, 8'd77);
        checks++;
        if (b_empty !== 1'b1 || b_cnt !== 3'd0 || b_top !== 8'd0) begin
            failures++;
            $display("FAIL clear_priority: got %h want empty", obs_vec(1));
        end
    endtask

    // Mixed random traffic with small keys so ties are frequent; newVal is X when not loading.
    task automatic test_random(input bit on_b, input int n);
        bit clr, ld, sh;
        logic [7:0] v;
        use_b = on_b;
        step(1, 0, 0, 8'bx);
        for (int i = 0; i < n; i++) begin
            clr = ($urandom_range(0, 99) < 3);
            ld  = ($urandom_range(0, 99) < 55);
            sh  = ($urandom_range(0, 99) < 45);
            v   = ld ? 8'($urandom_range(0, 15)) : 8'bx;
            step(clr, ld, sh, v);
            checks++;
            if (obs_vec(on_b) !== exp_vec()) begin
                failures++;
                $display("FAIL random inst%0d op %0d (c%0b l%0b s%0b v%h): got %h want %h",
                         on_b, i, clr, ld, sh, v, obs_vec(on_b), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_insert_order();
        test_overflow();
        test_replace();
        test_empty_ops();
        test_async_reset();
        test_min_first();
        test_random(1'b0, 400);
        test_random(1'b1, 300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pri_queue_sorted.md
# pri_queue_sorted

Parametrised sorted priority queue, the multi-bit, configurable-depth successor to the single-bit six-entry priority queue. It holds up to DEPTH keys of WIDTH bits in a systolic sorted register array and always presents the highest-priority key on `top`. It accepts one insert and/or one removal per clock, including both in the same cycle. It sits between a request producer and a scheduler/arbiter that drains it in priority order.

## Interface
- `WIDTH`, 8, key width in bits (>=1)
- `DEPTH`, 8, number of entries (>=2)
- `MAX_FIRST`, 1, 1: larger key is higher priority; 0: smaller key is higher priority
- `CW`, $clog2(DEPTH+1), width of `count` (derived, not overridden)

Ports:
- `ck`  in  1  clock, rising edge
- `r`  in  1  reset, asynchronous, active-low (r=0 resets)
- `clear`  in  1  synchronous flush of all entries
- `loadIn`  in  1  insert `newVal` this cycle
- `newVal`  in  WIDTH  key to insert
- `shiftOut`  in  1  remove current `top` this cycle
- `top`  out  WIDTH  highest-priority key; 0 when empty
- `topValid`  out  1  `top` holds a valid key
- `count`  out  CW  number of valid entries
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `overflow`  out  1  one-cycle pulse: a key was dropped by an insert into a full queue
- `underflow`  out  1  one-cycle pulse: `shiftOut` while empty

## Operation
- Storage e[0..DEPTH-1], each {valid, key}. Invariants: valid entries contiguous from e[0]; e[i] priority >= e[i+1]. "Better" means strictly greater key (MAX_FIRST=1) or strictly smaller key (MAX_FIRST=0).
- Ties: a new key goes behind all existing equal keys (FIFO among equals).
- Priority per cycle: `clear` > (`loadIn`, `shiftOut`). `clear`=1 invalidates all entries and zeroes keys. It raises no flags and ignores other inputs.
- Insert only (`loadIn`=1, `shiftOut`=0): p = lowest i with !valid[i] or newVal better than e[i]; p=DEPTH if none. Entries i>=p move to i+1, and e[p] takes newVal.
  - Full and p<DEPTH: e[DEPTH-1] is dropped and `overflow` pulses.
  - Full and p==DEPTH: newVal is dropped and `overflow` pulses.
  - count += 1 unless full.
- Remove only (`shiftOut`=1, `loadIn`=0): if non-empty, e[i] takes e[i+1], e[DEPTH-1] becomes invalid, count -= 1. If empty, state is unchanged and `underflow` pulses.
- Replace (`loadIn`=1, `shiftOut`=1, non-empty): e[0] is discarded and newVal is inserted among e[1..DEPTH-1] using the same rule. count is unchanged and neither flag is raised, even when full.
- Replace when empty: behaves as insert only, with no `underflow`.
- Per-entry logic compares only against the common newVal and its neighbours (compare vector, then one-hot mux select). There is no ripple search across entries.
- `top`/`topValid` are driven from e[0]. `full`, `empty` and `count` are registered alongside the array. `empty` = !valid[0], `full` = valid[DEPTH-1].

## Timing
- Inputs are sampled on rising `ck`. Every output is registered and reflects the operation one cycle later.
- Insert-to-`top` latency: 1 cycle. Sustained throughput: one operation per cycle, no stalls, no ready signal. The producer must watch `full` or tolerate drops.
- `overflow`/`underflow` are high for exactly the one cycle after the offending edge.
- Reset (r=0, asynchronous, any time including mid-operation): all valid=0, keys=0, `top`=0, `topValid`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0. The first operation is accepted on the first rising edge with r=1.
- X on `newVal` while `loadIn`=0 must not corrupt state.

## Test plan
- Reset then insert 5, 9, 2, 9 (DEPTH=4, WIDTH=8, MAX_FIRST=1), one per cycle -> `top` sequence 5, 9, 9, 9; `full`=1, `count`=4; successive `shiftOut` yields 9, 9, 5, 2, then `empty`=1.
- Full with {9,9,5,2}: insert 7 -> contents {9,9,7,5}, `overflow` pulses 1 cycle. Then insert 1 -> contents unchanged, `overflow` pulses.
- Full with {9,7,5,3}: `loadIn`+`shiftOut` with 6 -> `top`=7, contents {7,6,5,3}, `count`=4, no flags.
- Empty: `shiftOut` -> `underflow` pulses, `count`=0. `loadIn`+`shiftOut` with 4 -> `top`=4, `count`=1, no flags.
- MAX_FIRST=0: insert 5, 9, 2 -> `top`=2; removals yield 2, 5, 9. `clear` while `loadIn`=1 -> `empty`=1 next cycle, insert ignored.
- Assert r=0 between edges while count=3 -> outputs go to reset values immediately without waiting for `ck`. Insert 8 after release -> `top`=8, `count`=1.
